line_read_sched: RTL and testbench
==================================

# line_read_sched

Frame-capture scheduler that sequences the camera line buffer's read side. On a start request it triggers the line buffer and waits for it to arm. For each line it waits for the buffer's data-available flag, then issues exactly H_ACT read strobes. It re-presents the 16-bit RGB565 pixels as a ready/valid stream with pixel coordinates, for the DDR write path. It sits in the line buffer's read clock domain and is that buffer's only reader.

## Interface
- H_ACT, 1280, pixels per line (read strobes issued per line)
- V_ACT, 720, lines per frame
- TIMEOUT, 1_000_000, maximum cycles to wait for line buffer busy/acquire before aborting
- clk  in  1  read-side clock (same clock as line buffer read port)
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to capture one frame; ignored while busy
- lb_trig  out  1  one-cycle trigger pulse to line buffer
- lb_busy  in  1  line buffer busy (armed/capturing)
- lb_aquire  in  1  line buffer holds a readable line
- lb_read_en  out  1  read strobe; data returns one cycle later
- lb_data  in  16  pixel data, valid the cycle after lb_read_en
- out_valid  out  1  output pixel valid
- out_ready  in  1  downstream accepts pixel
- out_data  out  16  pixel
- out_x  out  $clog2(H_ACT)  pixel column
- out_y  out  $clog2(V_ACT)  pixel row
- out_eol  out  1  qualifies last pixel of a line (out_x==H_ACT-1)
- out_eof  out  1  qualifies last pixel of frame (eol and out_y==V_ACT-1)
- busy  out  1  high whenever state != IDLE
- frame_done  out  1  one-cycle pulse after the eof pixel is accepted
- abort  out  1  one-cycle pulse on timeout or premature lb_busy drop

## Operation
- States:
  - IDLE: accepts start, then moves to TRIG.
  - TRIG: lb_trig=1 for one cycle, then moves to ARM.
  - ARM: waits for lb_busy=1, then moves to WAIT_LINE.
  - WAIT_LINE: waits for lb_aquire=1, then moves to READ.
  - READ: issues reads. After the H_ACT-th strobe it moves to WAIT_LINE, or to DRAIN if the current line is V_ACT-1.
  - DRAIN: waits until the eof pixel handshakes. It then pulses frame_done and moves to IDLE.
- Line start rule: once in READ, the line buffer holds the full line, so lb_read_en is gated only by credit, never by lb_aquire.
- Credit rule: the 2-entry skid FIFO sits between lb_data and the output. The controller drives lb_read_en = (state==READ) && (rd_cnt < H_ACT) && (inflight + skid_count < 2). Here inflight is lb_read_en delayed by one cycle. The skid FIFO never overflows.
- Counters:
  - rd_cnt: counts strobes per line and clears on entry to READ.
  - line_cnt: counts completed read lines.
  - out_x/out_y: advance on each out_valid&&out_ready. out_x wraps to 0 at H_ACT-1 and out_y then increments; both clear to 0 in IDLE.
- Timeout: a counter runs in ARM and WAIT_LINE and clears on each state change. When it reaches TIMEOUT-1: pulse abort, flush the skid FIFO, drop inflight data, and go to IDLE.
- Premature end: lb_busy=0 in WAIT_LINE/READ while line_cnt < V_ACT behaves the same as a timeout: abort pulse, flush, IDLE. In DRAIN, lb_busy is ignored.
- A start pulse that arrives while busy is dropped; no queuing.
- The out_valid/out_data/out_x/out_y/out_eol/out_eof group stays stable while out_valid && !out_ready.

## Timing
- Reset values: lb_trig, lb_read_en, out_valid, out_eol, out_eof, busy, frame_done and abort are all 0. out_data, out_x and out_y are 0. State is IDLE and all counters are 0.
- Reset asserted mid-frame forces all of the above immediately (asynchronously); no abort pulse is generated.
- start sampled at cycle N: lb_trig=1 at N+1 and busy=1 from N+1.
- First lb_read_en comes 1 cycle after lb_aquire is sampled high in WAIT_LINE.
- Pixel latency: lb_read_en at cycle N gives out_valid at N+2 with the skid empty and out_ready=1.
- Throughput: 1 pixel/cycle sustained with out_ready held high. Maximum strobe rate is 1 per cycle under the credit rule.
- frame_done asserts the cycle after the eof handshake. busy falls in that same cycle.
- abort and frame_done are never asserted together.

## Test plan
- H_ACT=8, V_ACT=4, lb_busy and lb_aquire held 1, out_ready=1; pulse start.
  - Exactly 32 out_valid beats; out_x cycles 0..7, out_y 0..3.
  - out_eol on beats 8,16,24,32 and out_eof only on beat 32.
  - frame_done one cycle after beat 32.
- Same setup, out_ready toggling at random 50%.
  - lb_read_en never asserts with inflight+skid=2; no pixel lost or duplicated.
  - Data sequence matches the incrementing lb_data model.
- TIMEOUT=16, lb_busy stuck 0 after start → abort pulse at cycle 16 after entering ARM, busy=0, no lb_read_en ever issued.
- Drop lb_busy to 0 during line 2 of a frame → abort pulse next cycle, out_valid=0 after flush, and a subsequent start yields a full correct frame.
- Assert rst mid-READ → all outputs 0 asynchronously; a second start during an active frame is ignored (only one lb_trig pulse observed).

Source files
------------

// File: rtl/line_read_sched.sv
// line_read_sched: read-side sequencer for the camera line buffer.
// Arms the buffer on a start request, issues H_ACT read strobes per line under
// a two-entry credit, and re-presents pixels as a ready/valid stream tagged
// with x/y coordinates and end-of-line / end-of-frame qualifiers.
module line_read_sched #(
    parameter int H_ACT   = 1280,
    parameter int V_ACT   = 720,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     lb_trig,
    input  logic                     lb_busy,
    input  logic                     lb_aquire,
    output logic                     lb_read_en,
    input  logic [15:0]              lb_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_data,
    output logic [$clog2(H_ACT)-1:0] out_x,
    output logic [$clog2(V_ACT)-1:0] out_y,
    output logic                     out_eol,
    output logic                     out_eof,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     abort
);

    localparam int XW = $clog2(H_ACT);
    localparam int YW = $clog2(V_ACT);
    localparam int RW = $clog2(H_ACT + 1);
    localparam int LW = $clog2(V_ACT + 1);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        ARM,
        WAIT_LINE,
        READ,
        DRAIN
    } state_t;

    state_t        state;
    logic [RW-1:0] rd_cnt;
    logic [LW-1:0] line_cnt;
    logic [TW-1:0] tmo_cnt;

    // inflight: a strobe was issued last cycle, so lb_data is valid now
    logic          inflight;
    logic [1:0]    skid_count;
    logic          skid_rd_ptr;
    logic          skid_wr_ptr;
    logic [15:0]   skid_mem [2];

    logic          out_fire;
    logic          out_free;
    logic          tmo_hit;
    logic          busy_lost;
    logic          flush;
    logic          last_strobe;
    logic          skid_push;
    logic          skid_pop;

    assign out_fire    = out_valid && out_ready;
    // The output register can take a new pixel when empty or being accepted.
    assign out_free    = !out_valid || out_ready;
    // Credit: the skid FIFO must be able to absorb every strobe still in flight.
    assign lb_read_en  = (state == READ) && (rd_cnt < RW'(H_ACT)) &&
                         ((2'(inflight) + skid_count) < 2'd2);
    assign last_strobe = lb_read_en && (rd_cnt == RW'(H_ACT - 1));
    assign tmo_hit     = ((state == ARM) || (state == WAIT_LINE)) &&
                         (tmo_cnt == TW'(TIMEOUT - 1));
    // Every line of the frame is still owed while in WAIT_LINE/READ.
    assign busy_lost   = ((state == WAIT_LINE) || (state == READ)) && !lb_busy;
    assign flush       = tmo_hit || busy_lost;
    // Returning data bypasses the FIFO only when nothing older is queued.
    assign skid_pop    = out_free && (skid_count != 2'd0);
    assign skid_push   = inflight && !(out_free && (skid_count == 2'd0));

    assign busy        = (state != IDLE);
    assign out_eol     = out_valid && (out_x == XW'(H_ACT - 1));
    assign out_eof     = out_eol && (out_y == YW'(V_ACT - 1));

    // Frame sequencer: state, per-line/frame counters, timeout and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lb_trig    <= 1'b0;
            frame_done <= 1'b0;
            abort      <= 1'b0;
            rd_cnt     <= '0;
            line_cnt   <= '0;
            tmo_cnt    <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout; the defaults below
            // are overridden later in the same block, which makes every
            // status output a clean one-cycle pulse.
            lb_trig    <= 1'b0;
            frame_done <= 1'b0;
            abort      <= 1'b0;
            tmo_cnt    <= '0;
            case (state)
                IDLE: begin
                    rd_cnt   <= '0;
                    line_cnt <= '0;
                    if (start) begin
                        state   <= TRIG;
                        lb_trig <= 1'b1;
                    end
                end
                TRIG: begin
                    state <= ARM;
                end
                ARM: begin
                    if (tmo_hit) begin
                        abort <= 1'b1;
                        state <= IDLE;
                    end else if (lb_busy) begin
                        state <= WAIT_LINE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                WAIT_LINE: begin
                    if (flush) begin
                        abort <= 1'b1;
                        state <= IDLE;
                    end else if (lb_aquire) begin
                        rd_cnt <= '0;
                        state  <= READ;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                READ: begin
                    if (busy_lost) begin
                        abort <= 1'b1;
                        state <= IDLE;
                    end else if (lb_read_en) begin
                        rd_cnt <= rd_cnt + 1'b1;
                        if (last_strobe) begin
                            line_cnt <= line_cnt + 1'b1;
                            state    <= (line_cnt == LW'(V_ACT - 1)) ? DRAIN : WAIT_LINE;
                        end
                    end
                end
                DRAIN: begin
                    if (out_fire && out_eof) begin
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Pixel path: in-flight tracking, skid FIFO occupancy and the output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight    <= 1'b0;
            skid_count  <= 2'd0;
            skid_rd_ptr <= 1'b0;
            skid_wr_ptr <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
        end else if (flush) begin
            inflight    <= 1'b0;
            skid_count  <= 2'd0;
            skid_rd_ptr <= 1'b0;
            skid_wr_ptr <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            inflight <= lb_read_en;
            if (out_free) begin
                if (skid_count != 2'd0) begin
                    out_valid <= 1'b1;
                    out_data  <= skid_mem[skid_rd_ptr];
                end else if (inflight) begin
                    out_valid <= 1'b1;
                    out_data  <= lb_data;
                end else begin
                    out_valid <= 1'b0;
                end
            end
            if (skid_pop) begin
                skid_rd_ptr <= ~skid_rd_ptr;
            end
            if (skid_push) begin
                skid_wr_ptr <= ~skid_wr_ptr;
            end
            skid_count <= skid_count + 2'(skid_push) - 2'(skid_pop);
        end
    end

    // Skid storage write port.
    // NOTE: the storage array has no reset; skid_count alone decides which
    // entries are meaningful, so resetting the data would only add logic.
    always_ff @(posedge clk) begin
        if (skid_push) begin
            skid_mem[skid_wr_ptr] <= lb_data;
        end
    end

    // Output coordinates: advance per accepted pixel, cleared whenever idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_x <= '0;
            out_y <= '0;
        end else if ((state == IDLE) || flush) begin
            out_x <= '0;
            out_y <= '0;
        end else if (out_fire) begin
            if (out_x == XW'(H_ACT - 1)) begin
                out_x <= '0;
                out_y <= (out_y == YW'(V_ACT - 1)) ? '0 : out_y + 1'b1;
            end else begin
                out_x <= out_x + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_line_read_sched.sv
// tb_line_read_sched: directed frame scenarios with a behavioural line-buffer
// model; every accepted pixel is compared against its frame index.
module tb_line_read_sched;

    localparam int H_ACT   = 8;
    localparam int V_ACT   = 4;
    localparam int TIMEOUT = 16;
    localparam int NPIX    = H_ACT * V_ACT;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        lb_trig;
    logic        lb_busy;
    logic        lb_aquire;
    logic        lb_read_en;
    logic [15:0] lb_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  out_x;
    logic [1:0]  out_y;
    logic        out_eol;
    logic        out_eof;
    logic        busy;
    logic        frame_done;
    logic        abort;

    always #5 clk = ~clk;

    line_read_sched #(
        .H_ACT   (H_ACT),
        .V_ACT   (V_ACT),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .lb_trig    (lb_trig),
        .lb_busy    (lb_busy),
        .lb_aquire  (lb_aquire),
        .lb_read_en (lb_read_en),
        .lb_data    (lb_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_eol    (out_eol),
        .out_eof    (out_eof),
        .busy       (busy),
        .frame_done (frame_done),
        .abort      (abort)
    );

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          strobes = 0;
    int          total_strobes = 0;
    int          beats = 0;
    int          trigs = 0;
    int          dones = 0;
    int          aborts = 0;
    int          trig_cyc = 0;
    int          first_rd_cyc = 0;
    int          first_beat_cyc = 0;
    int          last_beat_cyc = 0;
    int          abort_cyc = 0;
    int          rd_pend_idx = 0;
    logic        rd_pend = 1'b0;
    logic        ready_mode = 1'b0;
    logic        stalled = 1'b0;
    logic [23:0] held = '0;
    logic [15:0] seed = 16'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pixel value the line buffer returns for the idx-th strobe of a frame.
    function automatic logic [15:0] pix_val(input int idx);
        return seed + 16'(idx * 257);
    endfunction

    // One clock cycle: line-buffer response, ready policy, scoreboard.
    task automatic step();
        int b;
        @(negedge clk);
        cyc++;
        if (rd_pend) lb_data = pix_val(rd_pend_idx);
        out_ready = ready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        if (lb_trig) begin
            trigs++;
            strobes  = 0;
            beats    = 0;
            trig_cyc = cyc;
        end
        if (abort || frame_done) check("abort_and_done", 32'(abort && frame_done), 32'd0);
        if (frame_done) begin
            dones++;
            check("done_beats", beats, NPIX);
            check("done_latency", cyc - last_beat_cyc, 32'd1);
            check("done_busy", 32'(busy), 32'd0);
        end
        if (abort) begin
            aborts++;
            abort_cyc = cyc;
        end
        if (stalled && !abort && !rst)
            check("stall_hold", 32'({out_valid, out_data, out_x, out_y, out_eol, out_eof}), 32'(held));
        if (lb_read_en) begin
            check("credit", 32'((strobes - beats - int'(out_valid)) < 2), 32'd1);
            if (strobes == 0) first_rd_cyc = cyc;
            rd_pend_idx = strobes;
            strobes++;
            total_strobes++;
        end
        rd_pend = lb_read_en;
        if (out_valid && out_ready) begin
            b = beats;
            check("px_data", 32'(out_data), 32'(pix_val(b)));
            check("px_x", 32'(out_x), b % H_ACT);
            check("px_y", 32'(out_y), b / H_ACT);
            check("px_eol", 32'(out_eol), 32'((b % H_ACT) == H_ACT - 1));
            check("px_eof", 32'(out_eof), 32'(b == NPIX - 1));
            if (b == 0) first_beat_cyc = cyc;
            last_beat_cyc = cyc;
            beats++;
        end
        stalled = out_valid && !out_ready;
        held    = {out_valid, out_data, out_x, out_y, out_eol, out_eof};
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        int d0 = dones;
        for (int i = 0; i < max_cyc && dones == d0; i++) step();
        check("frame_done_seen", dones - d0, 32'd1);
    endtask

    task automatic run_until_strobes(input int n, input int max_cyc);
        for (int i = 0; i < max_cyc && strobes < n; i++) step();
        check("strobes_reached", 32'(strobes >= n), 32'd1);
    endtask

    initial begin
        int a0;
        int s0;
        int d0;
        int tr0;
        rst       = 1'b1;
        start     = 1'b0;
        lb_busy   = 1'b1;
        lb_aquire = 1'b1;
        out_ready = 1'b1;
        lb_data   = '0;

        // Reset state
        repeat (2) step();
        check("rst_ctrl", 32'({lb_trig, lb_read_en, out_valid, out_eol, out_eof, busy, frame_done, abort}), 32'd0);
        check("rst_data_xy", 32'({out_data, out_x, out_y}), 32'd0);
        rst = 1'b0;
        step();
        check("idle_busy", 32'(busy), 32'd0);

        // Frame with out_ready held high
        seed = 16'h1000;
        pulse_start();
        check("start_trig", 32'(lb_trig), 32'd1);
        check("start_busy", 32'(busy), 32'd1);
        wait_done(200);
        check("t1_first_rd", first_rd_cyc - trig_cyc, 32'd3);
        check("t1_latency", first_beat_cyc - first_rd_cyc, 32'd2);
        check("t1_span", last_beat_cyc - first_beat_cyc, NPIX + V_ACT - 2);
        repeat (4) step();
        check("t1_beats_after", beats, NPIX);
        check("t1_xy_idle", 32'({out_x, out_y}), 32'd0);

        // Frame with out_ready toggling at random
        seed       = 16'hBEEF;
        ready_mode = 1'b1;
        pulse_start();
        wait_done(1000);
        ready_mode = 1'b0;
        repeat (4) step();
        check("t2_beats_after", beats, NPIX);

        // lb_busy never rises: timeout in ARM
        lb_busy = 1'b0;
        a0 = aborts;
        s0 = total_strobes;
        pulse_start();
        for (int i = 0; i < 100 && aborts == a0; i++) step();
        check("t3_abort_seen", aborts - a0, 32'd1);
        check("t3_abort_cycle", abort_cyc - trig_cyc, TIMEOUT + 1);
        check("t3_busy", 32'(busy), 32'd0);
        check("t3_no_reads", total_strobes - s0, 32'd0);
        lb_busy = 1'b1;
        step();

        // lb_busy drops during line 2, then a clean frame
        seed = 16'h4321;
        d0   = dones;
        pulse_start();
        run_until_strobes(2 * H_ACT + 3, 200);
        lb_busy = 1'b0;
        step();
        check("t4_abort", 32'(abort), 32'd1);
        check("t4_flushed", 32'(out_valid), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        lb_busy = 1'b1;
        repeat (3) step();
        check("t4_still_empty", 32'(out_valid), 32'd0);
        check("t4_no_done", dones - d0, 32'd0);
        seed = 16'h7A00;
        pulse_start();
        wait_done(200);

        // Second start during an active frame is dropped
        seed = 16'h0F0F;
        tr0  = trigs;
        pulse_start();
        run_until_strobes(5, 100);
        pulse_start();
        wait_done(200);
        check("t5_single_trig", trigs - tr0, 32'd1);

        // Asynchronous reset in the middle of READ
        seed = 16'h5555;
        pulse_start();
        run_until_strobes(H_ACT + 4, 100);
        #1 rst = 1'b1;
        #1;
        check("t5_async_rst",
              32'({lb_trig, lb_read_en, out_valid, out_eol, out_eof, busy, frame_done, abort, out_data, out_x, out_y}),
              32'd0);
        a0 = aborts;
        repeat (3) step();
        rst = 1'b0;
        repeat (3) step();
        check("t5_no_abort", aborts - a0, 32'd0);
        check("t5_idle", 32'(busy), 32'd0);

        // Recovery frame with random back-pressure
        seed       = 16'hC0DE;
        ready_mode = 1'b1;
        pulse_start();
        wait_done(1000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
